// File: rtl/xbar_pkg.sv
// Shared constants for the self-routing 2x2 crossbar: destination and priority encodings.
package xbar_pkg;

  localparam logic DEST_OUT1 = 1'b0;
  localparam logic DEST_OUT2 = 1'b1;
  localparam logic PRI_IN1   = 1'b0;
  localparam logic PRI_IN2   = 1'b1;

  // Pointer index width for a power-of-two FIFO depth.
  function automatic int log2_depth(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xbar_in_fifo.sv
// Per-input circular FIFO holding {dest, data}; pointers carry one extra wrap bit.
module xbar_in_fifo
  import xbar_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = log2_depth(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/crossbar_2x2_scheduler.sv
// Buffered self-routing 2x2 switch: two input FIFOs, round-robin conflict scheduler,
// and two registered output ports.
module crossbar_2x2_scheduler
  import xbar_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_dest,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_dest,
  output logic             in2_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic             out2_valid,
  output logic [WIDTH-1:0] out2_data,
  input  logic             out2_ready
);

  localparam int FW = WIDTH + 1;

  logic          f1_full, f1_empty, f2_full, f2_empty;
  logic [FW-1:0] head1, head2;
  logic          pop1, pop2;
  logic          pri;

  logic load1, load2;
  logic can1, can2, conflict;
  logic grant1, grant2;
  logic sel1_valid, sel2_valid;
  logic [WIDTH-1:0] sel1_data, sel2_data;

  // Valid/ready: a word moves on a rising edge where valid & ready are both high.
  // Input ready never depends on input valid; output data holds until ready is sampled high.
  assign in1_ready = !rst && !f1_full;
  assign in2_ready = !rst && !f2_full;

  xbar_in_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (in1_valid && in1_ready),
    .push_data ({in1_dest, in1_data}),
    .pop       (pop1),
    .full      (f1_full),
    .empty     (f1_empty),
    .head      (head1)
  );

  xbar_in_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo2 (
    .clk       (clk),
    .rst       (rst),
    .push      (in2_valid && in2_ready),
    .push_data ({in2_dest, in2_data}),
    .pop       (pop2),
    .full      (f2_full),
    .empty     (f2_empty),
    .head      (head2)
  );

  assign load1 = !out1_valid || out1_ready;
  assign load2 = !out2_valid || out2_ready;

  always_comb begin
    can1       = 1'b0;
    can2       = 1'b0;
    conflict   = 1'b0;
    grant1     = 1'b0;
    grant2     = 1'b0;
    sel1_valid = 1'b0;
    sel2_valid = 1'b0;
    sel1_data  = '0;
    sel2_data  = '0;

    can1 = !f1_empty && ((head1[WIDTH] == DEST_OUT1) ? load1 : load2);
    can2 = !f2_empty && ((head2[WIDTH] == DEST_OUT1) ? load1 : load2);
    // A conflict only exists when both heads could otherwise move into the same output.
    conflict = can1 && can2 && (head1[WIDTH] == head2[WIDTH]);
    grant1   = can1 && (!conflict || (pri == PRI_IN1));
    grant2   = can2 && (!conflict || (pri == PRI_IN2));

    if (grant1) begin
      if (head1[WIDTH] == DEST_OUT1) begin
        sel1_valid = 1'b1;
        sel1_data  = head1[WIDTH-1:0];
      end else begin
        sel2_valid = 1'b1;
        sel2_data  = head1[WIDTH-1:0];
      end
    end
    if (grant2) begin
      if (head2[WIDTH] == DEST_OUT1) begin
        sel1_valid = 1'b1;
        sel1_data  = head2[WIDTH-1:0];
      end else begin
        sel2_valid = 1'b1;
        sel2_data  = head2[WIDTH-1:0];
      end
    end
  end

  assign pop1 = grant1;
  assign pop2 = grant2;

  always_ff @(posedge clk) begin
    if (rst) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out2_valid <= 1'b0;
      out2_data  <= '0;
      pri        <= PRI_IN1;
    end else begin
      if (load1) begin
        out1_valid <= sel1_valid;
        if (sel1_valid) out1_data <= sel1_data;
      end
      if (load2) begin
        out2_valid <= sel2_valid;
        if (sel2_valid) out2_data <= sel2_data;
      end
      if (conflict) pri <= ~pri;
    end
  end

endmodule
